// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: opcode/funct encodings,
// ALU sub-op codes and result-class selectors.
package id_pkg;

   // Primary opcodes (inst[31:26])
   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_XORI    = 6'b001110;
   localparam logic [5:0] OP_LUI     = 6'b001111;

   // SPECIAL function codes (inst[5:0])
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_SRA = 6'b000011;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_NOR = 6'b100111;

   // ALU sub-operation codes
   localparam logic [7:0] EXE_NOP_OP = 8'h00;
   localparam logic [7:0] EXE_AND_OP = 8'h24;
   localparam logic [7:0] EXE_OR_OP  = 8'h25;
   localparam logic [7:0] EXE_XOR_OP = 8'h26;
   localparam logic [7:0] EXE_NOR_OP = 8'h27;
   localparam logic [7:0] EXE_SLL_OP = 8'h7C;
   localparam logic [7:0] EXE_SRL_OP = 8'h02;
   localparam logic [7:0] EXE_SRA_OP = 8'h03;

   // Result class selector
   typedef enum logic [2:0] {
      SEL_NOP   = 3'b000,
      SEL_LOGIC = 3'b001,
      SEL_SHIFT = 3'b010
   } alusel_e;

   // Number of register-file read ports
   localparam int NUM_RD = 2;

endpackage

// File: rtl/id_decode_core.sv
// Pure combinational instruction decoder: instruction word in, control
// fields, read-port enables/addresses and per-port immediates out.
module id_decode_core
   import id_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic [31:0]       inst,
   output logic [7:0]        aluop,
   output alusel_e           alusel,
   output logic [REG_AW-1:0] wd,
   output logic              wreg,
   output logic [1:0]        rd_en,
   output logic [REG_AW-1:0] rd_addr1,
   output logic [REG_AW-1:0] rd_addr2,
   output logic [DATA_W-1:0] imm1,
   output logic [DATA_W-1:0] imm2,
   output logic              instvalid
);

   logic [5:0]        op;
   logic [5:0]        fn;
   logic [REG_AW-1:0] rt_f;
   logic [REG_AW-1:0] rd_f;
   logic [DATA_W-1:0] imm_zext;
   logic [DATA_W-1:0] imm_lui;
   logic [DATA_W-1:0] sa_zext;
   logic              wreg_raw;

   assign op       = inst[31:26];
   assign fn       = inst[5:0];
   assign rd_addr1 = REG_AW'(inst[25:21]);
   assign rd_addr2 = REG_AW'(inst[20:16]);
   assign rt_f     = REG_AW'(inst[20:16]);
   assign rd_f     = REG_AW'(inst[15:11]);
   assign imm_zext = DATA_W'(inst[15:0]);
   assign imm_lui  = DATA_W'({inst[15:0], 16'h0000});
   assign sa_zext  = DATA_W'(inst[10:6]);

   // Map the encoding onto control fields; anything unrecognised stays NOP/illegal.
   always_comb begin
      aluop     = EXE_NOP_OP;
      alusel    = SEL_NOP;
      wd        = '0;
      wreg_raw  = 1'b0;
      rd_en     = 2'b00;
      imm1      = '0;
      imm2      = '0;
      instvalid = 1'b0;
      case (op)
         OP_ORI, OP_ANDI, OP_XORI: begin
            aluop     = (op == OP_ORI)  ? EXE_OR_OP :
                        (op == OP_ANDI) ? EXE_AND_OP : EXE_XOR_OP;
            alusel    = SEL_LOGIC;
            wd        = rt_f;
            wreg_raw  = 1'b1;
            rd_en     = 2'b01;
            imm2      = imm_zext;
            instvalid = 1'b1;
         end
         OP_LUI: begin
            // rs is not read: port 1 is forced to zero so OR passes imm through.
            aluop     = EXE_OR_OP;
            alusel    = SEL_LOGIC;
            wd        = rt_f;
            wreg_raw  = 1'b1;
            imm1      = '0;
            imm2      = imm_lui;
            instvalid = 1'b1;
         end
         OP_SPECIAL: begin
            case (fn)
               FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                  aluop     = (fn == FN_AND) ? EXE_AND_OP :
                              (fn == FN_OR)  ? EXE_OR_OP  :
                              (fn == FN_XOR) ? EXE_XOR_OP : EXE_NOR_OP;
                  alusel    = SEL_LOGIC;
                  wd        = rd_f;
                  wreg_raw  = 1'b1;
                  rd_en     = 2'b11;
                  instvalid = 1'b1;
               end
               FN_SLL, FN_SRL, FN_SRA: begin
                  // Shift amount rides on port 1, the value to shift on port 2.
                  aluop     = (fn == FN_SLL) ? EXE_SLL_OP :
                              (fn == FN_SRL) ? EXE_SRL_OP : EXE_SRA_OP;
                  alusel    = SEL_SHIFT;
                  wd        = rd_f;
                  wreg_raw  = 1'b1;
                  rd_en     = 2'b10;
                  imm1      = sa_zext;
                  instvalid = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   // Writes to $0 are architecturally dropped.
   assign wreg = wreg_raw & (wd != '0);

endmodule

// File: rtl/id_stage.sv
// Registered decode stage: decodes, resolves operands through EX/MEM
// forwarding, detects load-use / RAW hazards and owns the ID/EX register.
module id_stage
   import id_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int FWD_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid_i,
   output logic              if_ready_o,
   input  logic [31:0]       pc_i,
   input  logic [31:0]       inst_i,
   output logic              reg1_read_o,
   output logic [REG_AW-1:0] reg1_addr_o,
   input  logic [DATA_W-1:0] reg1_data_i,
   output logic              reg2_read_o,
   output logic [REG_AW-1:0] reg2_addr_o,
   input  logic [DATA_W-1:0] reg2_data_i,
   input  logic              ex_wreg_i,
   input  logic [REG_AW-1:0] ex_wd_i,
   input  logic [DATA_W-1:0] ex_wdata_i,
   input  logic              ex_is_load_i,
   input  logic              mem_wreg_i,
   input  logic [REG_AW-1:0] mem_wd_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   input  logic              flush_i,
   input  logic              ex_ready_i,
   output logic              ex_valid_o,
   output logic [31:0]       ex_pc_o,
   output logic [7:0]        aluop_o,
   output logic [2:0]        alusel_o,
   output logic [DATA_W-1:0] reg1_o,
   output logic [DATA_W-1:0] reg2_o,
   output logic [REG_AW-1:0] wd_o,
   output logic              wreg_o,
   output logic              instvalid_o
);

   localparam logic FWD_ON = (FWD_EN != 0);

   logic [7:0]        dec_aluop;
   alusel_e           dec_alusel;
   logic [REG_AW-1:0] dec_wd;
   logic              dec_wreg;
   logic              dec_instvalid;
   logic [1:0]        dec_rd_en;
   logic [REG_AW-1:0] rd_addr [NUM_RD];
   logic [DATA_W-1:0] rd_data [NUM_RD];
   logic [DATA_W-1:0] dec_imm [NUM_RD];
   logic [DATA_W-1:0] opnd    [NUM_RD];
   logic [NUM_RD-1:0] port_haz;

   logic stall;
   logic hold;
   logic accept;

   logic              ex_valid_reg;
   logic [31:0]       ex_pc_reg;
   logic [7:0]        aluop_reg;
   logic [2:0]        alusel_reg;
   logic [DATA_W-1:0] reg1_reg;
   logic [DATA_W-1:0] reg2_reg;
   logic [REG_AW-1:0] wd_reg;
   logic              wreg_reg;
   logic              instvalid_reg;

   id_decode_core #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_decode (
      .inst      (inst_i),
      .aluop     (dec_aluop),
      .alusel    (dec_alusel),
      .wd        (dec_wd),
      .wreg      (dec_wreg),
      .rd_en     (dec_rd_en),
      .rd_addr1  (rd_addr[0]),
      .rd_addr2  (rd_addr[1]),
      .imm1      (dec_imm[0]),
      .imm2      (dec_imm[1]),
      .instvalid (dec_instvalid)
   );

   assign reg1_read_o = dec_rd_en[0];
   assign reg2_read_o = dec_rd_en[1];
   assign reg1_addr_o = rd_addr[0];
   assign reg2_addr_o = rd_addr[1];
   assign rd_data[0]  = reg1_data_i;
   assign rd_data[1]  = reg2_data_i;

   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
      logic              live;
      logic              ex_hit;
      logic              mem_hit;
      logic [DATA_W-1:0] val;

      assign live    = dec_rd_en[gi] & (rd_addr[gi] != '0);
      assign ex_hit  = ex_wreg_i  & (ex_wd_i  == rd_addr[gi]);
      assign mem_hit = mem_wreg_i & (mem_wd_i == rd_addr[gi]);

      // Operand select: immediate on non-read ports, $0 reads zero, else EX > MEM > regfile.
      always_comb begin
         val = rd_data[gi];
         if (!dec_rd_en[gi])
            val = dec_imm[gi];
         else if (rd_addr[gi] == '0)
            val = '0;
         else if (FWD_ON && ex_hit)
            val = ex_wdata_i;
         else if (FWD_ON && mem_hit)
            val = mem_wdata_i;
      end

      assign opnd[gi] = val;

      // A load in EX cannot forward yet; without forwarding any pending write blocks.
      assign port_haz[gi] = live & ((ex_hit & ex_is_load_i) |
                                    (~FWD_ON & (ex_hit | mem_hit)));
   end

   assign stall      = |port_haz;
   assign hold       = ex_valid_reg & ~ex_ready_i;
   assign if_ready_o = flush_i | (~stall & ~hold);
   assign accept     = if_valid_i & if_ready_o & ~flush_i;

   // ID/EX register: flush > hold > accept > bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid_reg  <= 1'b0;
         ex_pc_reg     <= '0;
         aluop_reg     <= '0;
         alusel_reg    <= '0;
         reg1_reg      <= '0;
         reg2_reg      <= '0;
         wd_reg        <= '0;
         wreg_reg      <= 1'b0;
         instvalid_reg <= 1'b0;
      end else if (flush_i) begin
         ex_valid_reg <= 1'b0;
         wreg_reg     <= 1'b0;
      end else if (hold) begin
         ex_valid_reg <= ex_valid_reg;
      end else if (accept) begin
         ex_valid_reg  <= 1'b1;
         ex_pc_reg     <= pc_i;
         aluop_reg     <= dec_aluop;
         alusel_reg    <= dec_alusel;
         reg1_reg      <= opnd[0];
         reg2_reg      <= opnd[1];
         wd_reg        <= dec_wd;
         wreg_reg      <= dec_wreg;
         instvalid_reg <= dec_instvalid;
      end else begin
         ex_valid_reg <= 1'b0;
         wreg_reg     <= 1'b0;
      end
   end

   assign ex_valid_o  = ex_valid_reg;
   assign ex_pc_o     = ex_pc_reg;
   assign aluop_o     = aluop_reg;
   assign alusel_o    = alusel_reg;
   assign reg1_o      = reg1_reg;
   assign reg2_o      = reg2_reg;
   assign wd_o        = wd_reg;
   assign wreg_o      = wreg_reg;
   assign instvalid_o = instvalid_reg;

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: two instances (forwarding on / off) share stimulus
// and are checked against a behavioural model of the decode stage.
module tb_id_stage;

   localparam int DW = 32;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          if_valid, flush, ex_ready;
   logic [31:0]   pc, inst;
   logic [DW-1:0] reg1_data, reg2_data;
   logic          ex_wreg, ex_is_load, mem_wreg;
   logic [AW-1:0] ex_wd, mem_wd;
   logic [DW-1:0] ex_wdata, mem_wdata;

   logic          if_ready    [2];
   logic          reg1_read   [2];
   logic          reg2_read   [2];
   logic [AW-1:0] reg1_addr   [2];
   logic [AW-1:0] reg2_addr   [2];
   logic          ex_valid    [2];
   logic [31:0]   ex_pc       [2];
   logic [7:0]    aluop       [2];
   logic [2:0]    alusel      [2];
   logic [DW-1:0] reg1_q      [2];
   logic [DW-1:0] reg2_q      [2];
   logic [AW-1:0] wd_q        [2];
   logic          wreg_q      [2];
   logic          instvalid_q [2];

   logic [31:0] rf [32];

   // Register file contents seen on the read ports
   always_comb begin
      reg1_data = rf[inst[25:21]];
      reg2_data = rf[inst[20:16]];
   end

   id_stage #(.DATA_W(DW), .REG_AW(AW), .FWD_EN(1)) u_dut_fwd (
      .clk(clk), .rst(rst), .if_valid_i(if_valid), .if_ready_o(if_ready[0]),
      .pc_i(pc), .inst_i(inst),
      .reg1_read_o(reg1_read[0]), .reg1_addr_o(reg1_addr[0]), .reg1_data_i(reg1_data),
      .reg2_read_o(reg2_read[0]), .reg2_addr_o(reg2_addr[0]), .reg2_data_i(reg2_data),
      .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_is_load),
      .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
      .flush_i(flush), .ex_ready_i(ex_ready), .ex_valid_o(ex_valid[0]), .ex_pc_o(ex_pc[0]),
      .aluop_o(aluop[0]), .alusel_o(alusel[0]), .reg1_o(reg1_q[0]), .reg2_o(reg2_q[0]),
      .wd_o(wd_q[0]), .wreg_o(wreg_q[0]), .instvalid_o(instvalid_q[0])
   );

   id_stage #(.DATA_W(DW), .REG_AW(AW), .FWD_EN(0)) u_dut_nofwd (
      .clk(clk), .rst(rst), .if_valid_i(if_valid), .if_ready_o(if_ready[1]),
      .pc_i(pc), .inst_i(inst),
      .reg1_read_o(reg1_read[1]), .reg1_addr_o(reg1_addr[1]), .reg1_data_i(reg1_data),
      .reg2_read_o(reg2_read[1]), .reg2_addr_o(reg2_addr[1]), .reg2_data_i(reg2_data),
      .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_is_load),
      .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
      .flush_i(flush), .ex_ready_i(ex_ready), .ex_valid_o(ex_valid[1]), .ex_pc_o(ex_pc[1]),
      .aluop_o(aluop[1]), .alusel_o(alusel[1]), .reg1_o(reg1_q[1]), .reg2_o(reg2_q[1]),
      .wd_o(wd_q[1]), .wreg_o(wreg_q[1]), .instvalid_o(instvalid_q[1])
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic        legal;
      logic [7:0]  aluop;
      logic [2:0]  sel;
      logic [4:0]  wd;
      logic        wr;
      logic        use_rs;
      logic        use_rt;
      logic [31:0] fix1;
      logic [31:0] fix2;
   } dec_t;

   function automatic dec_t model_decode(input logic [31:0] w);
      dec_t d;
      d = '0;
      case (w[31:26])
         6'h0C, 6'h0D, 6'h0E: begin
            d.legal = 1; d.sel = 3'd1; d.use_rs = 1; d.wd = w[20:16];
            d.fix2  = {16'h0000, w[15:0]};
            d.aluop = (w[31:26] == 6'h0C) ? 8'h24 : (w[31:26] == 6'h0D) ? 8'h25 : 8'h26;
         end
         6'h0F: begin
            d.legal = 1; d.sel = 3'd1; d.aluop = 8'h25; d.wd = w[20:16];
            d.fix1 = 32'h0; d.fix2 = {w[15:0], 16'h0000};
         end
         6'h00: begin
            case (w[5:0])
               6'h24: begin d.legal = 1; d.aluop = 8'h24; end
               6'h25: begin d.legal = 1; d.aluop = 8'h25; end
               6'h26: begin d.legal = 1; d.aluop = 8'h26; end
               6'h27: begin d.legal = 1; d.aluop = 8'h27; end
               6'h00: begin d.legal = 1; d.aluop = 8'h7C; end
               6'h02: begin d.legal = 1; d.aluop = 8'h02; end
               6'h03: begin d.legal = 1; d.aluop = 8'h03; end
               default: ;
            endcase
            if (d.legal) begin
               d.wd = w[15:11];
               d.use_rt = 1;
               if (w[5]) begin
                  d.sel = 3'd1; d.use_rs = 1;
               end else begin
                  d.sel = 3'd2; d.fix1 = {27'h0, w[10:6]};
               end
            end
         end
         default: ;
      endcase
      d.wr = d.legal && (d.wd != 5'd0);
      return d;
   endfunction

   function automatic logic [31:0] resolve(input logic use_p, input logic [4:0] a,
                                           input logic [31:0] fix, input bit fwd);
      if (!use_p) return fix;
      if (a == 5'd0) return 32'h0;
      if (fwd && ex_wreg && ex_wd == a) return ex_wdata;
      if (fwd && mem_wreg && mem_wd == a) return mem_wdata;
      return rf[a];
   endfunction

   function automatic bit port_blocked(input logic use_p, input logic [4:0] a, input bit fwd);
      if (!use_p || a == 5'd0) return 0;
      if (ex_wreg && ex_is_load && ex_wd == a) return 1;
      if (!fwd && ((ex_wreg && ex_wd == a) || (mem_wreg && mem_wd == a))) return 1;
      return 0;
   endfunction

   // Model state; m_lvl says how much of the ID/EX contents is defined:
   // 0 valid only, 1 +wreg, 2 +pc/aluop/alusel/instvalid, 3 everything.
   logic        m_valid [2];
   logic [31:0] m_pc    [2];
   logic [7:0]  m_aluop [2];
   logic [2:0]  m_sel   [2];
   logic [31:0] m_r1    [2];
   logic [31:0] m_r2    [2];
   logic [4:0]  m_wd    [2];
   logic        m_wreg  [2];
   logic        m_iv    [2];
   int          m_lvl   [2];
   bit          last_rdy[2];
   int          cyc = 0;

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_valid[k] = 0; m_pc[k] = 0; m_aluop[k] = 0; m_sel[k] = 0; m_r1[k] = 0;
         m_r2[k] = 0; m_wd[k] = 0; m_wreg[k] = 0; m_iv[k] = 0; m_lvl[k] = 3;
      end
   endtask

   task automatic compare_outputs();
      for (int k = 0; k < 2; k++) begin
         check_val($sformatf("ex_valid[%0d]", k), 64'(ex_valid[k]), 64'(m_valid[k]));
         if (m_lvl[k] >= 1)
            check_val($sformatf("wreg[%0d]", k), 64'(wreg_q[k]), 64'(m_wreg[k]));
         if (m_lvl[k] >= 2) begin
            check_val($sformatf("ex_pc[%0d]", k), 64'(ex_pc[k]), 64'(m_pc[k]));
            check_val($sformatf("aluop[%0d]", k), 64'(aluop[k]), 64'(m_aluop[k]));
            check_val($sformatf("alusel[%0d]", k), 64'(alusel[k]), 64'(m_sel[k]));
            check_val($sformatf("instvalid[%0d]", k), 64'(instvalid_q[k]), 64'(m_iv[k]));
         end
         if (m_lvl[k] >= 3) begin
            check_val($sformatf("reg1[%0d]", k), 64'(reg1_q[k]), 64'(m_r1[k]));
            check_val($sformatf("reg2[%0d]", k), 64'(reg2_q[k]), 64'(m_r2[k]));
            check_val($sformatf("wd[%0d]", k), 64'(wd_q[k]), 64'(m_wd[k]));
         end
      end
   endtask

   // One clock: inputs already applied (edge+1); check comb outputs at the
   // falling edge, then registered outputs 1 time unit after the rising edge.
   task automatic step();
      dec_t        d;
      bit          st, hd, rdy;
      int          act [2];
      logic [31:0] n_r1 [2];
      logic [31:0] n_r2 [2];
      logic [31:0] cur_pc;
      @(negedge clk);
      d = model_decode(inst);
      cur_pc = pc;
      for (int k = 0; k < 2; k++) begin
         st  = port_blocked(d.use_rs, inst[25:21], k == 0) || port_blocked(d.use_rt, inst[20:16], k == 0);
         hd  = m_valid[k] && !ex_ready;
         rdy = flush || (!st && !hd);
         last_rdy[k] = if_ready[k];
         check_val($sformatf("if_ready[%0d]", k), 64'(if_ready[k]), 64'(rdy));
         check_val($sformatf("reg1_read[%0d]", k), 64'(reg1_read[k]), 64'(d.use_rs));
         check_val($sformatf("reg2_read[%0d]", k), 64'(reg2_read[k]), 64'(d.use_rt));
         check_val($sformatf("reg1_addr[%0d]", k), 64'(reg1_addr[k]), 64'(inst[25:21]));
         check_val($sformatf("reg2_addr[%0d]", k), 64'(reg2_addr[k]), 64'(inst[20:16]));
         if (flush) act[k] = 0;
         else if (hd) act[k] = 1;
         else if (if_valid && rdy) act[k] = 2;
         else act[k] = 3;
         n_r1[k] = resolve(d.use_rs, inst[25:21], d.fix1, k == 0);
         n_r2[k] = resolve(d.use_rt, inst[20:16], d.fix2, k == 0);
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < 2; k++) begin
         case (act[k])
            0: begin m_valid[k] = 0; m_lvl[k] = 0; end
            1: ;
            2: begin
               m_valid[k] = 1; m_pc[k] = cur_pc; m_aluop[k] = d.aluop; m_sel[k] = d.sel;
               m_wd[k] = d.wd; m_wreg[k] = d.wr; m_iv[k] = d.legal;
               m_r1[k] = n_r1[k]; m_r2[k] = n_r2[k];
               m_lvl[k] = d.legal ? 3 : 2;
            end
            default: begin m_valid[k] = 0; m_wreg[k] = 0; m_lvl[k] = 1; end
         endcase
      end
      compare_outputs();
      $display("cyc %0d inst=%h act=%0d/%0d valid=%b/%b rdy=%b/%b", cyc, inst, act[0], act[1],
               ex_valid[0], ex_valid[1], last_rdy[0], last_rdy[1]);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      model_reset();
      for (int k = 0; k < 2; k++) begin
         check_val($sformatf("rst ex_valid[%0d]", k), 64'(ex_valid[k]), 64'(0));
         check_val($sformatf("rst ex_pc[%0d]", k), 64'(ex_pc[k]), 64'(0));
         check_val($sformatf("rst aluop[%0d]", k), 64'(aluop[k]), 64'(0));
         check_val($sformatf("rst alusel[%0d]", k), 64'(alusel[k]), 64'(0));
         check_val($sformatf("rst reg1[%0d]", k), 64'(reg1_q[k]), 64'(0));
         check_val($sformatf("rst reg2[%0d]", k), 64'(reg2_q[k]), 64'(0));
         check_val($sformatf("rst wd[%0d]", k), 64'(wd_q[k]), 64'(0));
         check_val($sformatf("rst wreg[%0d]", k), 64'(wreg_q[k]), 64'(0));
         check_val($sformatf("rst instvalid[%0d]", k), 64'(instvalid_q[k]), 64'(0));
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic idle();
      if_valid = 0; flush = 0; ex_ready = 1; pc = 0; inst = 0;
      ex_wreg = 0; ex_wd = 0; ex_wdata = 0; ex_is_load = 0;
      mem_wreg = 0; mem_wd = 0; mem_wdata = 0;
   endtask

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sa, fn};
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [4:0] rs, rt, rd;
      logic [5:0] fns [7];
      fns = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03};
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
         0: return enc_i(6'h0D, rs, rt, 16'($urandom));
         1: return enc_i(6'h0C, rs, rt, 16'($urandom));
         2: return enc_i(6'h0E, rs, rt, 16'($urandom));
         3: return enc_i(6'h0F, 5'd0, rt, 16'($urandom));
         4, 5: return enc_r(rs, rt, rd, 5'($urandom), fns[$urandom_range(0, 6)]);
         6: return enc_i(($urandom_range(0, 1) != 0) ? 6'h3F : 6'h23, rs, rt, 16'($urandom));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rf[1] = 32'h1111_0001;
      rf[5] = 32'h5555_0005;
      idle();
      #2;
      do_reset();

      // ori $1,$0,0x1100
      if_valid = 1; pc = 32'h100; inst = enc_i(6'h0D, 5'd0, 5'd1, 16'h1100);
      step();
      check_val("ori valid", 64'(ex_valid[0]), 64'(1));
      check_val("ori reg1", 64'(reg1_q[0]), 64'(0));
      check_val("ori reg2", 64'(reg2_q[0]), 64'(32'h1100));
      check_val("ori wd", 64'(wd_q[0]), 64'(1));
      check_val("ori wreg", 64'(wreg_q[0]), 64'(1));
      check_val("ori aluop", 64'(aluop[0]), 64'(8'h25));

      // or $3,$1,$2 with EX and MEM both writing $1: EX wins
      pc = 32'h104; inst = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h25);
      ex_wreg = 1; ex_wd = 1; ex_wdata = 32'hA;
      mem_wreg = 1; mem_wd = 1; mem_wdata = 32'hB;
      step();
      check_val("fwd ex>mem reg1", 64'(reg1_q[0]), 64'(32'hA));

      // $0 source with EX writing $0
      pc = 32'h108; inst = enc_r(5'd0, 5'd2, 5'd3, 5'd0, 6'h25);
      ex_wd = 0; ex_wdata = 32'h55; mem_wreg = 0;
      step();
      check_val("zero src reg1", 64'(reg1_q[0]), 64'(0));

      // load-use: and $4,$2,$5 behind a load to $2
      pc = 32'h10C; inst = enc_r(5'd2, 5'd5, 5'd4, 5'd0, 6'h24);
      ex_wreg = 1; ex_wd = 2; ex_wdata = 32'h999; ex_is_load = 1;
      step();
      check_val("load-use ready", 64'(last_rdy[0]), 64'(0));
      check_val("load-use bubble", 64'(ex_valid[0]), 64'(0));
      ex_wreg = 0; ex_is_load = 0; mem_wreg = 1; mem_wd = 2; mem_wdata = 32'h77;
      step();
      check_val("load-use resume ready", 64'(last_rdy[0]), 64'(1));
      check_val("load-use resume valid", 64'(ex_valid[0]), 64'(1));
      check_val("load-use fwd reg1", 64'(reg1_q[0]), 64'(32'h77));

      // no forwarding: ori $2,$1,1 stalls while MEM writes $1
      pc = 32'h110; inst = enc_i(6'h0D, 5'd1, 5'd2, 16'h0001);
      mem_wreg = 1; mem_wd = 1; mem_wdata = 32'hDEAD;
      repeat (2) begin
         step();
         check_val("nofwd stall ready", 64'(last_rdy[1]), 64'(0));
         check_val("nofwd stall valid", 64'(ex_valid[1]), 64'(0));
      end
      mem_wreg = 0;
      step();
      check_val("nofwd accept valid", 64'(ex_valid[1]), 64'(1));
      check_val("nofwd regfile reg1", 64'(reg1_q[1]), 64'(rf[1]));

      // back-pressure two cycles, then flush
      pc = 32'h114; inst = enc_i(6'h0E, 5'd2, 5'd3, 16'h00FF); ex_ready = 0;
      repeat (2) begin
         step();
         check_val("hold ready", 64'(last_rdy[0]), 64'(0));
         check_val("hold pc", 64'(ex_pc[0]), 64'(32'h110));
      end
      flush = 1;
      step();
      check_val("flush valid0", 64'(ex_valid[0]), 64'(0));
      check_val("flush valid1", 64'(ex_valid[1]), 64'(0));

      // illegal opcode
      flush = 0; ex_ready = 1; pc = 32'h118; inst = {6'h3F, 26'h1234567};
      step();
      check_val("illegal valid", 64'(ex_valid[0]), 64'(1));
      check_val("illegal instvalid", 64'(instvalid_q[0]), 64'(0));
      check_val("illegal wreg", 64'(wreg_q[0]), 64'(0));

      // randomized traffic with a reset in the middle
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset();
         if_valid   = ($urandom_range(0, 4) != 0);
         pc         = $urandom;
         inst       = rand_inst();
         ex_wreg    = ($urandom_range(0, 1) != 0);
         ex_wd      = 5'($urandom_range(0, 3));
         ex_wdata   = $urandom;
         ex_is_load = ($urandom_range(0, 3) == 0);
         mem_wreg   = ($urandom_range(0, 1) != 0);
         mem_wd     = 5'($urandom_range(0, 3));
         mem_wdata  = $urandom;
         flush      = ($urandom_range(0, 15) == 0);
         ex_ready   = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
